// File: rtl/execute_single_if.sv
// execute_single_if: decoded-context input bundle and flat memory-stage output bundle of the
// execute stage.
//   slave  modport - the execute stage: consumes in_*, stage_ready, flush; drives busy, out_*.
//   master modport - the controller/decoder side: drives in_*, stage_ready, flush.
interface execute_single_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_sdata;
  logic [4:0]  in_dst;
  logic        stage_ready;
  logic        flush;

  logic        busy;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_op;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic        out_write;
  logic [1:0]  out_msize;
  logic [4:0]  out_dst;
  logic [31:0] out_value;
  logic        out_src_mem;
  logic        out_hilo_we;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        out_ex_valid;
  logic [4:0]  out_ex_code;

  modport slave (
    input  in_valid, in_pc, in_op, in_a, in_b, in_sdata, in_dst, stage_ready, flush,
    output busy, out_valid, out_pc, out_op, out_addr, out_wdata, out_write, out_msize,
           out_dst, out_value, out_src_mem, out_hilo_we, out_hi, out_lo, out_ex_valid,
           out_ex_code
  );

  modport master (
    output in_valid, in_pc, in_op, in_a, in_b, in_sdata, in_dst, stage_ready, flush,
    input  busy, out_valid, out_pc, out_op, out_addr, out_wdata, out_write, out_msize,
           out_dst, out_value, out_src_mem, out_hilo_we, out_hi, out_lo, out_ex_valid,
           out_ex_code
  );
endinterface

// File: rtl/execute_single.sv
// execute_single: in-order execute stage feeding the memory stage.
// Registers the decoded context, computes ALU results, load/store address and store data,
// single-cycle MULT/MULTU and an iterative restoring DIV/DIVU (one quotient bit per cycle).
// Ports:
//   clk    - clock
//   resetn - synchronous, active-low reset
//   ex     - execute_single_if.slave: decoded context in, memory-stage context out, busy
module execute_single #(
  parameter int unsigned DIV_ITERS = 32
) (
  input logic             clk,
  input logic             resetn,
  execute_single_if.slave ex
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITERS - 1);

  localparam logic [4:0] OpAdd   = 5'd1;
  localparam logic [4:0] OpAddu  = 5'd2;
  localparam logic [4:0] OpSub   = 5'd3;
  localparam logic [4:0] OpSubu  = 5'd4;
  localparam logic [4:0] OpAnd   = 5'd5;
  localparam logic [4:0] OpOr    = 5'd6;
  localparam logic [4:0] OpXor   = 5'd7;
  localparam logic [4:0] OpNor   = 5'd8;
  localparam logic [4:0] OpSlt   = 5'd9;
  localparam logic [4:0] OpSltu  = 5'd10;
  localparam logic [4:0] OpSll   = 5'd11;
  localparam logic [4:0] OpSrl   = 5'd12;
  localparam logic [4:0] OpSra   = 5'd13;
  localparam logic [4:0] OpLui   = 5'd14;
  localparam logic [4:0] OpLb    = 5'd15;
  localparam logic [4:0] OpLbu   = 5'd16;
  localparam logic [4:0] OpLh    = 5'd17;
  localparam logic [4:0] OpLhu   = 5'd18;
  localparam logic [4:0] OpLw    = 5'd19;
  localparam logic [4:0] OpSb    = 5'd20;
  localparam logic [4:0] OpSh    = 5'd21;
  localparam logic [4:0] OpSw    = 5'd22;
  localparam logic [4:0] OpMult  = 5'd23;
  localparam logic [4:0] OpMultu = 5'd24;
  localparam logic [4:0] OpDiv   = 5'd25;
  localparam logic [4:0] OpDivu  = 5'd26;

  typedef enum logic [1:0] {DivIdle, DivRun, DivDone} div_state_e;

  logic            ctx_valid_q, ctx_valid_d;
  logic [31:0]     ctx_pc_q, ctx_pc_d;
  logic [4:0]      ctx_op_q, ctx_op_d;
  logic [31:0]     ctx_a_q, ctx_a_d;
  logic [31:0]     ctx_b_q, ctx_b_d;
  logic [31:0]     ctx_sdata_q, ctx_sdata_d;
  logic [4:0]      ctx_dst_q, ctx_dst_d;
  div_state_e      div_state_q, div_state_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]     div_rem_q, div_rem_d;
  logic [31:0]     div_quo_q, div_quo_d;
  logic [31:0]     div_dvs_q, div_dvs_d;

  logic        busy;
  logic        valid;
  logic        in_is_div;
  logic        in_signed;
  logic [32:0] rem_shift;
  logic [32:0] trial;

  assign busy      = (div_state_q == DivRun);
  assign valid     = ctx_valid_q & ~busy;
  assign in_is_div = ex.in_valid & ((ex.in_op == OpDiv) | (ex.in_op == OpDivu));
  assign in_signed = (ex.in_op == OpDiv);
  // Restoring step: shift the next dividend bit into the partial remainder and try subtracting.
  assign rem_shift = {div_rem_q, div_quo_q[31]};
  assign trial     = rem_shift - {1'b0, div_dvs_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctx_valid_q <= 1'b0;
      ctx_pc_q    <= '0;
      ctx_op_q    <= '0;
      ctx_a_q     <= '0;
      ctx_b_q     <= '0;
      ctx_sdata_q <= '0;
      ctx_dst_q   <= '0;
      div_state_q <= DivIdle;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_dvs_q   <= '0;
    end else begin
      ctx_valid_q <= ctx_valid_d;
      ctx_pc_q    <= ctx_pc_d;
      ctx_op_q    <= ctx_op_d;
      ctx_a_q     <= ctx_a_d;
      ctx_b_q     <= ctx_b_d;
      ctx_sdata_q <= ctx_sdata_d;
      ctx_dst_q   <= ctx_dst_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_dvs_q   <= div_dvs_d;
    end
  end

  always_comb begin
    ctx_valid_d = ctx_valid_q;
    ctx_pc_d    = ctx_pc_q;
    ctx_op_d    = ctx_op_q;
    ctx_a_d     = ctx_a_q;
    ctx_b_d     = ctx_b_q;
    ctx_sdata_d = ctx_sdata_q;
    ctx_dst_d   = ctx_dst_q;
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_dvs_d   = div_dvs_q;

    if (ex.flush) begin
      ctx_valid_d = 1'b0;
      div_state_d = DivIdle;
    end else if (busy) begin
      if (!trial[32]) begin
        div_rem_d = trial[31:0];
        div_quo_d = {div_quo_q[30:0], 1'b1};
      end else begin
        div_rem_d = rem_shift[31:0];
        div_quo_d = {div_quo_q[30:0], 1'b0};
      end
      div_cnt_d = div_cnt_q + 1'b1;
      if (div_cnt_q == CntLast) begin
        div_state_d = DivDone;
      end
    end else if (ex.stage_ready) begin
      // Latching drops any finished divide result; the memory stage has already taken it.
      ctx_valid_d = ex.in_valid;
      ctx_pc_d    = ex.in_pc;
      ctx_op_d    = ex.in_op;
      ctx_a_d     = ex.in_a;
      ctx_b_d     = ex.in_b;
      ctx_sdata_d = ex.in_sdata;
      ctx_dst_d   = ex.in_dst;
      div_state_d = DivIdle;
      if (in_is_div) begin
        div_state_d = DivRun;
        div_cnt_d   = '0;
        div_rem_d   = '0;
        div_quo_d   = (in_signed && ex.in_a[31]) ? -ex.in_a : ex.in_a;
        div_dvs_d   = (in_signed && ex.in_b[31]) ? -ex.in_b : ex.in_b;
      end
    end
  end

  // Result datapath, combinational from the registered context.
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_add;
  logic        ovf_sub;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        div_by_zero;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  assign sum     = ctx_a_q + ctx_b_q;
  assign diff    = ctx_a_q - ctx_b_q;
  assign ovf_add = (ctx_a_q[31] == ctx_b_q[31]) & (sum[31] ^ ctx_a_q[31]);
  assign ovf_sub = (ctx_a_q[31] != ctx_b_q[31]) & (diff[31] ^ ctx_a_q[31]);
  assign prod_s  = $signed({{32{ctx_a_q[31]}}, ctx_a_q}) * $signed({{32{ctx_b_q[31]}}, ctx_b_q});
  assign prod_u  = {32'h0, ctx_a_q} * {32'h0, ctx_b_q};

  // Signs are restored from the held context; divide-by-zero is a fixed pattern.
  assign div_signed  = (ctx_op_q == OpDiv);
  assign div_by_zero = (ctx_b_q == 32'h0);
  assign div_lo = div_by_zero ? 32'hFFFF_FFFF :
                  (div_signed && (ctx_a_q[31] ^ ctx_b_q[31])) ? -div_quo_q : div_quo_q;
  assign div_hi = div_by_zero ? ctx_a_q :
                  (div_signed && ctx_a_q[31]) ? -div_rem_q : div_rem_q;

  logic        writes_gpr;
  logic        ovf;
  logic        hilo;
  logic        store;
  logic        load;
  logic [31:0] hi;
  logic [31:0] lo;

  always_comb begin
    writes_gpr    = 1'b0;
    ovf           = 1'b0;
    hilo          = 1'b0;
    store         = 1'b0;
    load          = 1'b0;
    hi            = '0;
    lo            = '0;
    ex.out_addr   = '0;
    ex.out_wdata  = '0;
    ex.out_msize  = 2'd0;
    ex.out_value  = '0;

    case (ctx_op_q)
      OpAdd:   begin writes_gpr = 1'b1; ovf = ovf_add; ex.out_value = sum; end
      OpAddu:  begin writes_gpr = 1'b1; ex.out_value = sum; end
      OpSub:   begin writes_gpr = 1'b1; ovf = ovf_sub; ex.out_value = diff; end
      OpSubu:  begin writes_gpr = 1'b1; ex.out_value = diff; end
      OpAnd:   begin writes_gpr = 1'b1; ex.out_value = ctx_a_q & ctx_b_q; end
      OpOr:    begin writes_gpr = 1'b1; ex.out_value = ctx_a_q | ctx_b_q; end
      OpXor:   begin writes_gpr = 1'b1; ex.out_value = ctx_a_q ^ ctx_b_q; end
      OpNor:   begin writes_gpr = 1'b1; ex.out_value = ~(ctx_a_q | ctx_b_q); end
      OpSlt:   begin
        writes_gpr   = 1'b1;
        ex.out_value = {31'h0, ($signed(ctx_a_q) < $signed(ctx_b_q))};
      end
      OpSltu:  begin writes_gpr = 1'b1; ex.out_value = {31'h0, (ctx_a_q < ctx_b_q)}; end
      OpSll:   begin writes_gpr = 1'b1; ex.out_value = ctx_b_q << ctx_a_q[4:0]; end
      OpSrl:   begin writes_gpr = 1'b1; ex.out_value = ctx_b_q >> ctx_a_q[4:0]; end
      OpSra:   begin
        writes_gpr   = 1'b1;
        ex.out_value = $unsigned($signed(ctx_b_q) >>> ctx_a_q[4:0]);
      end
      OpLui:   begin writes_gpr = 1'b1; ex.out_value = {ctx_b_q[15:0], 16'h0}; end
      OpLb, OpLbu: begin
        writes_gpr = 1'b1; load = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd0;
      end
      OpLh, OpLhu: begin
        writes_gpr = 1'b1; load = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd1;
      end
      OpLw:    begin writes_gpr = 1'b1; load = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd2; end
      OpSb:    begin
        store = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd0;
        ex.out_wdata = {4{ctx_sdata_q[7:0]}};
      end
      OpSh:    begin
        store = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd1;
        ex.out_wdata = {2{ctx_sdata_q[15:0]}};
      end
      OpSw:    begin
        store = 1'b1; ex.out_addr = sum; ex.out_msize = 2'd2; ex.out_wdata = ctx_sdata_q;
      end
      OpMult:  begin hilo = 1'b1; hi = prod_s[63:32]; lo = prod_s[31:0]; end
      OpMultu: begin hilo = 1'b1; hi = prod_u[63:32]; lo = prod_u[31:0]; end
      OpDiv, OpDivu: begin hilo = 1'b1; hi = div_hi; lo = div_lo; end
      default: ;
    endcase

    ex.busy         = busy;
    ex.out_valid    = valid;
    ex.out_pc       = ctx_pc_q;
    ex.out_op       = ctx_op_q;
    // An overflowing ADD/SUB still reports its value but must not reach the register file.
    ex.out_dst      = (writes_gpr && !ovf) ? ctx_dst_q : 5'd0;
    ex.out_write    = store & ctx_valid_q;
    ex.out_src_mem  = load & ctx_valid_q;
    ex.out_ex_valid = ovf & ctx_valid_q;
    ex.out_ex_code  = (ovf && ctx_valid_q) ? 5'h0C : 5'h00;
    // HI/LO only escape once the context is valid and any divide has finished.
    ex.out_hilo_we  = hilo & valid;
    ex.out_hi       = valid ? hi : 32'h0;
    ex.out_lo       = valid ? lo : 32'h0;
  end

endmodule

// File: doc/execute_single.md
Name: execute_single

Overview:
- In-order execute stage; sits directly upstream of the memory stage.
- Registers the decoded context and computes ALU results, load/store effective addresses and store data.
- Computes MULT/MULTU results in a single cycle and DIV/DIVU results with an iterative 32-cycle divider.
- Presents a flat memory-stage context and raises a stall request while the divider is busy.

Parameters:
- DIV_ITERS, 32, number of divider iterations; one quotient bit per cycle; fixed at 32 for word operands.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_pc  in  32  instruction PC
- in_op  in  5  opcode: 0 NOP,1 ADD,2 ADDU,3 SUB,4 SUBU,5 AND,6 OR,7 XOR,8 NOR,9 SLT,10 SLTU,11 SLL,12 SRL,13 SRA,14 LUI,15 LB,16 LBU,17 LH,18 LHU,19 LW,20 SB,21 SH,22 SW,23 MULT,24 MULTU,25 DIV,26 DIVU; 27-31 treated as NOP
- in_a  in  32  rs value; shift amount is in_a[4:0]
- in_b  in  32  rt value, or immediate already extended
- in_sdata  in  32  rt value for stores
- in_dst  in  5  destination register
- stage_ready  in  1  1 = load new context at the edge; 0 = hold current context
- flush  in  1  kill current context (exception/ERET from a later stage)
- busy  out  1  divider running; the controller must stall upstream
- out_valid  out  1  context valid and result final
- out_pc  out  32  registered PC
- out_op  out  5  registered opcode
- out_addr  out  32  effective address in_a+in_b, for ops 15-22
- out_wdata  out  32  store data: in_sdata[7:0] replicated ×4 for SB, [15:0] ×2 for SH, full word for SW
- out_write  out  1  store
- out_msize  out  2  0 byte, 1 half, 2 word
- out_dst  out  5  destination register; 0 when no write
- out_value  out  32  ALU result; 0 for loads (the memory stage fills it)
- out_src_mem  out  1  load: value comes from memory
- out_hilo_we  out  1  HI/LO write
- out_hi  out  32  HI result
- out_lo  out  32  LO result
- out_ex_valid  out  1  exception
- out_ex_code  out  5  0x0C (Ov) when out_ex_valid=1, else 0

Behaviour:
- Reset:
  - Synchronous on resetn=0.
  - Context valid, divider state and all outputs go to 0; divider FSM goes to IDLE.
- Context register:
  - At each edge the priority order is: resetn=0 → reset; else flush=1 → valid cleared, divider aborted to IDLE; else busy=1 → hold context (stage_ready ignored); else stage_ready=1 → latch in_*; else hold.
  - When busy=0 and stage_ready=1 on the same edge, the new context is latched and any finished divide result is dropped, because the memory stage has already taken it.
- Single-cycle ops:
  - Result is combinational from the registered context.
  - out_valid = ctx_valid & ~busy.
  - SLT is signed; SLTU is unsigned.
  - SRA is arithmetic; shifts operate on in_b.
  - LUI result = {in_b[15:0], 16'h0}.
- Overflow:
  - ADD/SUB signed overflow gives out_ex_valid=1 and out_ex_code=0x0C.
  - out_dst is forced to 0 and out_value is still driven.
  - ADDU/SUBU never raise.
- MULT/MULTU: 64-bit product in the same cycle; out_hi=product[63:32], out_lo=product[31:0], out_hilo_we=1.
- Divider FSM (IDLE → RUN → DONE):
  - The edge that latches DIV/DIVU moves the FSM to RUN, with counter=0 and magnitudes loaded.
  - RUN: one restoring step per edge. After DIV_ITERS steps the FSM moves to DONE; busy=1 throughout RUN.
  - DONE: busy=0; the result is held until the next latch or flush, then the FSM returns to IDLE.
  - Latency: a DIV latched at edge E0 gives out_valid=1 after edge E32, i.e. busy is high for 32 cycles.
  - Signed DIV: divide magnitudes. Quotient is negated iff in_a[31]^in_b[31]; remainder takes the sign of in_a.
  - Results: out_lo = quotient, out_hi = remainder.
  - Divisor 0 (signed or unsigned): out_lo=0xFFFFFFFF and out_hi=in_a; full 32-cycle latency and no exception.
  - 0x80000000 / -1 (signed): out_lo=0x80000000, out_hi=0.
- Flush mid-divide: busy drops the next cycle, out_valid=0, and no HI/LO write escapes.
- Ops 27-31 and NOP: out_valid still follows ctx_valid; out_dst=0; no side effects.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → out_ex_valid=1, out_ex_code=0x0C, out_dst=0. ADDU with the same operands → out_value=0x80000000, no exception.
- SB a=0x1000, b=3, sdata=0x12345678 → out_addr=0x1003, out_wdata=0x78787878, out_msize=0, out_write=1. LW gives out_src_mem=1, out_value=0.
- DIV a=-7, b=2 latched at E0, stage_ready=1 throughout → busy high for 32 cycles and the context is held. After E32: out_lo=0xFFFFFFFD, out_hi=0xFFFFFFFF, out_hilo_we=1.
- DIVU a=5, b=0 → out_lo=0xFFFFFFFF, out_hi=5 after 32 cycles.
- MULT a=0xFFFFFFFF, b=2 → out_hi=0xFFFFFFFF, out_lo=0xFFFFFFFE in the latch cycle. MULTU with the same operands → out_hi=1, out_lo=0xFFFFFFFE.
- DIV running, flush at iteration 10 → next cycle busy=0, out_valid=0. resetn=0 mid-divide → all outputs 0 next cycle.
